// File: rtl/alu_result_buffer.sv
// Registered result FIFO between the scalar ALU and writeback.
// Also owns the architectural Z/N flag register, which updates when an entry is pushed.
module alu_result_buffer #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 4,
    parameter int DEPTH  = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_result,
    input  logic                       in_flagZ,
    input  logic                       in_flagN,
    input  logic [REG_AW-1:0]          in_rd,
    input  logic                       in_we,
    input  logic                       in_setflags,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_result,
    output logic [REG_AW-1:0]          out_rd,
    output logic                       out_we,
    output logic                       flag_z,
    output logic                       flag_n,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_W-1:0] resultMem_q [DEPTH];
    logic [REG_AW-1:0] rdMem_q     [DEPTH];
    logic              weMem_q     [DEPTH];

    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             flagZ_q, flagZ_d;
    logic             flagN_q, flagN_d;

    logic push;
    logic pop;

    // in_ready looks only at occupancy, so a full buffer refuses a push even while it pops.
    assign in_ready  = (count_q < FULL_CNT) & ~rst;
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    assign out_result = out_valid ? resultMem_q[rdPtr_q] : '0;
    assign out_rd     = out_valid ? rdMem_q[rdPtr_q]     : '0;
    assign out_we     = out_valid & weMem_q[rdPtr_q];
    assign flag_z     = flagZ_q;
    assign flag_n     = flagN_q;
    assign count      = count_q;

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        flagZ_d = flagZ_q;
        flagN_d = flagN_q;
        if (push) begin
            wrPtr_d = wrPtr_q + PTR_W'(1);
            if (in_setflags) begin
                flagZ_d = in_flagZ;
                flagN_d = in_flagN;
            end
        end
        if (pop) begin
            rdPtr_d = rdPtr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            flagZ_q <= 1'b0;
            flagN_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                resultMem_q[i] <= '0;
                rdMem_q[i]     <= '0;
                weMem_q[i]     <= 1'b0;
            end
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
            flagZ_q <= flagZ_d;
            flagN_q <= flagN_d;
            if (push) begin
                resultMem_q[wrPtr_q] <= in_result;
                rdMem_q[wrPtr_q]     <= in_rd;
                weMem_q[wrPtr_q]     <= in_we;
            end
        end
    end

endmodule

// File: tb/tb_alu_result_buffer.sv
// Directed bench for alu_result_buffer: handshakes, full/refuse behaviour, flag ownership,
// streaming with pointer wrap and asynchronous reset.
module tb_alu_result_buffer;

    logic        clk;
    logic        rst;
    logic        inValid;
    logic        inReady;
    logic [15:0] inResult;
    logic        inFlagZ;
    logic        inFlagN;
    logic [3:0]  inRd;
    logic        inWe;
    logic        inSetflags;
    logic        outValid;
    logic        outReady;
    logic [15:0] outResult;
    logic [3:0]  outRd;
    logic        outWe;
    logic        flagZ;
    logic        flagN;
    logic [1:0]  count;

    int checks = 0;
    int failures = 0;

    alu_result_buffer #(.DATA_W(16), .REG_AW(4), .DEPTH(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (inValid),
        .in_ready   (inReady),
        .in_result  (inResult),
        .in_flagZ   (inFlagZ),
        .in_flagN   (inFlagN),
        .in_rd      (inRd),
        .in_we      (inWe),
        .in_setflags(inSetflags),
        .out_valid  (outValid),
        .out_ready  (outReady),
        .out_result (outResult),
        .out_rd     (outRd),
        .out_we     (outWe),
        .flag_z     (flagZ),
        .flag_n     (flagN),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one upstream beat; inputs change 1ns after a rising edge, away from the sample point.
    task automatic applyStimulus(input logic v, input logic [15:0] res, input logic [3:0] rd,
                                 input logic we, input logic sf, input logic z, input logic n);
        inValid    = v;
        inResult   = res;
        inRd       = rd;
        inWe       = we;
        inSetflags = sf;
        inFlagZ    = z;
        inFlagN    = n;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        outReady = 1'b0;
        applyStimulus(0, 16'h0, 4'h0, 0, 0, 0, 0);
        tick();
        tick();
        checkOutput("rst_out_valid", 32'(outValid), 0);
        checkOutput("rst_out_result", 32'(outResult), 0);
        checkOutput("rst_out_rd", 32'(outRd), 0);
        checkOutput("rst_out_we", 32'(outWe), 0);
        checkOutput("rst_in_ready", 32'(inReady), 0);
        checkOutput("rst_count", 32'(count), 0);
        checkOutput("rst_flags", 32'({flagZ, flagN}), 0);
        rst = 1'b0;
        #1;
        checkOutput("post_rst_in_ready", 32'(inReady), 1);

        $display("[TB] single push, one-cycle latency");
        outReady = 1'b1;
        applyStimulus(1, 16'h1234, 4'd3, 1, 1, 0, 1);
        tick();
        applyStimulus(0, 16'h0, 4'h0, 0, 0, 0, 0);
        checkOutput("single_valid", 32'(outValid), 1);
        checkOutput("single_result", 32'(outResult), 32'h1234);
        checkOutput("single_rd", 32'(outRd), 3);
        checkOutput("single_we", 32'(outWe), 1);
        checkOutput("single_flag_n", 32'(flagN), 1);
        checkOutput("single_flag_z", 32'(flagZ), 0);
        tick();
        checkOutput("single_drain_valid", 32'(outValid), 0);
        checkOutput("single_drain_result", 32'(outResult), 0);

        $display("[TB] stalled writeback, third push refused");
        outReady = 1'b0;
        applyStimulus(1, 16'd1, 4'd1, 1, 0, 0, 0);
        tick();
        checkOutput("stall_count1", 32'(count), 1);
        applyStimulus(1, 16'd2, 4'd2, 1, 0, 0, 0);
        tick();
        checkOutput("stall_count2", 32'(count), 2);
        checkOutput("stall_in_ready", 32'(inReady), 0);
        applyStimulus(1, 16'd3, 4'd3, 1, 0, 0, 0);
        tick();
        checkOutput("stall_hold_count", 32'(count), 2);
        checkOutput("stall_hold_result", 32'(outResult), 1);
        checkOutput("stall_hold_rd", 32'(outRd), 1);
        outReady = 1'b1;
        tick();
        checkOutput("release_count", 32'(count), 1);
        checkOutput("release_result2", 32'(outResult), 2);
        checkOutput("release_in_ready", 32'(inReady), 1);
        tick();
        checkOutput("third_accept_count", 32'(count), 1);
        checkOutput("third_result", 32'(outResult), 3);
        applyStimulus(0, 16'h0, 4'h0, 0, 0, 0, 0);
        tick();
        checkOutput("stall_drained", 32'(count), 0);

        $display("[TB] full buffer with simultaneous push and pop");
        outReady = 1'b0;
        applyStimulus(1, 16'hA0A0, 4'd4, 1, 0, 0, 0);
        tick();
        applyStimulus(1, 16'hB0B0, 4'd5, 0, 0, 0, 0);
        tick();
        checkOutput("full_count", 32'(count), 2);
        applyStimulus(1, 16'hC0C0, 4'd6, 1, 0, 0, 0);
        outReady = 1'b1;
        tick();
        checkOutput("full_pop_count", 32'(count), 1);
        checkOutput("full_pop_head", 32'(outResult), 32'hB0B0);
        checkOutput("full_pop_we", 32'(outWe), 0);
        outReady = 1'b0;
        tick();
        checkOutput("refill_count", 32'(count), 2);
        checkOutput("refill_head", 32'(outResult), 32'hB0B0);
        applyStimulus(0, 16'h0, 4'h0, 0, 0, 0, 0);
        outReady = 1'b1;
        tick();
        checkOutput("refill_c_result", 32'(outResult), 32'hC0C0);
        checkOutput("refill_c_rd", 32'(outRd), 6);
        tick();
        checkOutput("refill_drained", 32'(count), 0);

        $display("[TB] flag ownership");
        applyStimulus(1, 16'h0000, 4'd1, 1, 1, 1, 0);
        tick();
        checkOutput("flags_set", 32'({flagZ, flagN}), 32'b10);
        applyStimulus(1, 16'h8000, 4'd2, 1, 0, 0, 1);
        tick();
        checkOutput("flags_nosf", 32'({flagZ, flagN}), 32'b10);
        outReady = 1'b0;
        applyStimulus(1, 16'h0011, 4'd3, 1, 0, 0, 0);
        tick();
        checkOutput("flags_fill_count", 32'(count), 2);
        applyStimulus(1, 16'h8001, 4'd4, 1, 1, 0, 1);
        tick();
        checkOutput("flags_refused", 32'({flagZ, flagN}), 32'b10);
        checkOutput("flags_refused_count", 32'(count), 2);
        applyStimulus(0, 16'h0, 4'h0, 0, 0, 0, 0);
        outReady = 1'b1;
        tick();
        tick();
        checkOutput("flags_drained", 32'(count), 0);

        $display("[TB] streaming 10 entries");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, 16'(i), 4'(i), 1, 0, 0, 0);
            tick();
            checkOutput("stream_result", 32'(outResult), 32'(i));
            checkOutput("stream_count", 32'(count), 1);
        end
        applyStimulus(0, 16'h0, 4'h0, 0, 0, 0, 0);
        tick();
        checkOutput("stream_drained", 32'(count), 0);

        $display("[TB] asynchronous reset mid-cycle");
        outReady = 1'b0;
        applyStimulus(1, 16'h5555, 4'd8, 1, 1, 1, 1);
        tick();
        applyStimulus(1, 16'h6666, 4'd9, 1, 0, 0, 0);
        tick();
        applyStimulus(0, 16'h0, 4'h0, 0, 0, 0, 0);
        checkOutput("prereset_count", 32'(count), 2);
        checkOutput("prereset_flags", 32'({flagZ, flagN}), 32'b11);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_valid", 32'(outValid), 0);
        checkOutput("async_count", 32'(count), 0);
        checkOutput("async_flags", 32'({flagZ, flagN}), 0);
        checkOutput("async_result", 32'(outResult), 0);
        checkOutput("async_in_ready", 32'(inReady), 0);
        tick();
        rst = 1'b0;
        applyStimulus(1, 16'hBEEF, 4'd7, 0, 0, 0, 0);
        tick();
        applyStimulus(0, 16'h0, 4'h0, 0, 0, 0, 0);
        checkOutput("after_rst_valid", 32'(outValid), 1);
        checkOutput("after_rst_result", 32'(outResult), 32'hBEEF);
        checkOutput("after_rst_rd", 32'(outRd), 7);
        checkOutput("after_rst_we", 32'(outWe), 0);
        checkOutput("after_rst_count", 32'(count), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_result_buffer.md
# alu_result_buffer

Registered output stage directly downstream of the scalar 16-bit ALU. It captures each ALU result (C) together with its zero/negative flags and writeback tag, and holds it in a small FIFO with valid/ready handshakes toward writeback. It also maintains the architectural Z/N flag register used by conditional branches. It decouples the combinational ALU path from writeback stalls and is the single owner of the flag state.

## Interface
Parameters:
- DATA_W, 16, result width; matches ALU C.
- REG_AW, 4, destination register address width.
- DEPTH, 2, FIFO entries; power of two, ≥2.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  ALU result valid this cycle.
- in_ready  out  1  buffer can accept an entry.
- in_result  in  DATA_W  ALU output C.
- in_flagZ  in  1  ALU flagZ.
- in_flagN  in  1  ALU flagN.
- in_rd  in  REG_AW  destination register.
- in_we  in  1  instruction writes a register.
- in_setflags  in  1  instruction updates architectural flags.
- out_valid  out  1  head entry present.
- out_ready  in  1  writeback accepts head.
- out_result  out  DATA_W  head result; 0 when empty.
- out_rd  out  REG_AW  head destination; 0 when empty.
- out_we  out  1  head write enable, ANDed with out_valid.
- flag_z  out  1  architectural Z flag.
- flag_n  out  1  architectural N flag.
- count  out  $clog2(DEPTH+1)  current occupancy.

## Operation
- Push = in_valid & in_ready. Pop = out_valid & out_ready.
- in_ready = (count < DEPTH) & ~rst. It does not depend on out_ready, so there is no combinational in→out path. When the buffer is full, a push is refused even if a pop happens in the same cycle.
- Each entry stores {result, rd, we}. ALU flags are not stored per entry.
- On push: write the entry at wr_ptr, then wr_ptr = (wr_ptr+1) mod DEPTH.
- On pop: rd_ptr = (rd_ptr+1) mod DEPTH.
- Count update: +1 on push only, −1 on pop only, unchanged on simultaneous push and pop (only possible when 0 < count < DEPTH).
- Flag register: on push with in_setflags=1, flag_z ← in_flagZ and flag_n ← in_flagN. The flags update at push, not at pop, so branches see flags in program order ahead of writeback.
- in_setflags is ignored when in_valid is high but the push is refused. Flags hold otherwise.
- No bypass: an entry pushed into an empty buffer appears on out_* the following cycle.
- out_result/out_rd/out_we come from the head entry. They are forced to 0 when count==0.
- Holding rule: while out_valid=1 and out_ready=0, all out_* are stable.
- Upstream obligation: the source must hold in_* stable while in_valid=1 and in_ready=0. The block does not check this.

## Timing
- Reset (asynchronous, immediate) clears count, wr_ptr, rd_ptr, flag_z and flag_n to 0, and all entry storage to 0. Resulting outputs: out_valid=0, out_result=0, out_rd=0, out_we=0, in_ready=0 while rst=1, then 1 on the first cycle after deassertion.
- Reset mid-operation discards all buffered entries; no pop is reported.
- Latency is 1 cycle from push edge to out_valid=1 (empty buffer). Flags are visible 1 cycle after the push edge.
- Throughput is 1 entry/cycle when out_ready=1 continuously.
- in_ready falls the cycle after the push that fills the buffer. It rises the cycle after the first pop from full.
- Pointers wrap modulo DEPTH with no gap. count never exceeds DEPTH and never underflows; a pop request when empty is a no-op.

## Test plan
- Reset, then a single push of result=16'h1234, rd=3, we=1, setflags=1, Z=0, N=1 with out_ready=1 → next cycle out_valid=1, out_result=16'h1234, out_rd=3, out_we=1, flag_n=1, flag_z=0. The cycle after, out_valid=0 and out_result=0.
- Hold out_ready=0 and push 3 entries (1, 2, 3) back to back → first two accepted, count=2, in_ready=0 on the 3rd. Then release out_ready=1 → outputs 1, 2 in order; the 3rd is accepted only after the first pop.
- Full buffer with in_valid=1 and out_ready=1 in the same cycle → pop occurs, push refused, count 2→1. The next cycle's push is accepted and count returns to 2.
- Push with setflags=1 (Z=1), then push with setflags=0 (Z=0, N=1) → flag_z stays 1 and flag_n stays 0 after the second push. A refused push with setflags=1 leaves the flags unchanged.
- Continuous streaming of 10 entries (values 0..9) with out_ready=1 → 1 output per cycle in order, count ≤1, pointers wrap correctly.
- Assert rst asynchronously (mid-cycle) with 2 entries buffered → out_valid, count and flags go to 0 immediately, before the next edge. After release, the first new push appears with correct data.
